// File: rtl/pipe_scheduler.sv
// Per-frame pipe controller for the two-pipe flappy-bird playfield: phase FSM,
// pipe scrolling/respawn with LFSR gap heights, and pass counting.
module pipe_scheduler #(
    parameter int unsigned SPEED     = 2,
    parameter int unsigned SPAWN_X   = 409,
    parameter int unsigned SPACING   = 205,
    parameter int unsigned GAP_MIN   = 80,
    parameter int unsigned GAP_H     = 120,
    parameter int unsigned BIRD_X    = 100,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       gameover,
    output logic [9:0] pipe1_x,
    output logic [9:0] up_pipe1_y,
    output logic [9:0] down_pipe1_y,
    output logic [9:0] pipe2_x,
    output logic [9:0] up_pipe2_y,
    output logic [9:0] down_pipe2_y,
    output logic       running,
    output logic       pass_pulse,
    output logic [9:0] score
);
    localparam logic [9:0] SpeedW    = 10'(SPEED);
    localparam logic [9:0] Spawn1W   = 10'(SPAWN_X);
    localparam logic [9:0] Spawn2W   = 10'(SPAWN_X + SPACING);
    localparam logic [9:0] SpacingW  = 10'(SPACING);
    localparam logic [9:0] GapMinW   = 10'(GAP_MIN);
    localparam logic [9:0] GapHW     = 10'(GAP_H);
    localparam logic [9:0] BirdXW    = 10'(BIRD_X);
    localparam logic [9:0] UpReset   = 10'd150;
    localparam logic [9:0] DownReset = 10'd270;
    localparam logic [9:0] ScoreMax  = 10'd1023;

    typedef enum logic [1:0] {StIdle, StRun, StOver} state_e;

    state_e     state_q, state_d;
    logic [7:0] lfsr_q, lfsr_d;
    logic [9:0] p1_x_q, p1_x_d, p2_x_q, p2_x_d;
    logic [9:0] up1_q, up1_d, up2_q, up2_d;
    logic [9:0] down1_q, down1_d, down2_q, down2_d;
    logic [9:0] score_q, score_d;
    logic       pass_q, pass_d;
    logic       running_q, running_d;

    logic       p1_resp, p2_resp, pass1, pass2;
    logic [9:0] p1_mv, p2_mv, spawn_up;

    assign p1_resp  = p1_x_q < SpeedW;
    assign p2_resp  = p2_x_q < SpeedW;
    assign p1_mv    = p1_x_q - SpeedW;
    assign p2_mv    = p2_x_q - SpeedW;
    assign spawn_up = GapMinW + {3'b000, lfsr_q[6:0]};
    assign pass1    = !p1_resp && (p1_x_q >= BirdXW) && (p1_mv < BirdXW);
    assign pass2    = !p2_resp && (p2_x_q >= BirdXW) && (p2_mv < BirdXW);

    always_comb begin
        // x^8+x^6+x^5+x^4+1, shifting left
        lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        state_d = state_q;
        p1_x_d  = p1_x_q;
        p2_x_d  = p2_x_q;
        up1_d   = up1_q;
        up2_d   = up2_q;
        down1_d = down1_q;
        down2_d = down2_q;
        score_d = score_q;
        pass_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StRun;
            end
            StRun: begin
                if (gameover) begin
                    state_d = StOver;
                end else if (frame_tick) begin
                    if (p1_resp && p2_resp) begin
                        p1_x_d = Spawn1W;
                        p2_x_d = Spawn2W;
                    end else begin
                        // pipe2 first: pipe1's respawn chains off pipe2's new x
                        p2_x_d = p2_resp ? p1_mv + SpacingW : p2_mv;
                        p1_x_d = p1_resp ? p2_x_d + SpacingW : p1_mv;
                    end
                    if (p1_resp) begin
                        up1_d   = spawn_up;
                        down1_d = spawn_up + GapHW;
                    end
                    if (p2_resp) begin
                        up2_d   = spawn_up;
                        down2_d = spawn_up + GapHW;
                    end
                    if (pass1 || pass2) begin
                        pass_d = 1'b1;
                        if (score_q != ScoreMax) score_d = score_q + 10'd1;
                    end
                end
            end
            StOver: begin
                if (start) begin
                    state_d = StIdle;
                    p1_x_d  = Spawn1W;
                    p2_x_d  = Spawn2W;
                    up1_d   = UpReset;
                    up2_d   = UpReset;
                    down1_d = DownReset;
                    down2_d = DownReset;
                    score_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
        running_d = (state_d == StRun);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            lfsr_q    <= LFSR_SEED;
            p1_x_q    <= Spawn1W;
            p2_x_q    <= Spawn2W;
            up1_q     <= UpReset;
            up2_q     <= UpReset;
            down1_q   <= DownReset;
            down2_q   <= DownReset;
            score_q   <= '0;
            pass_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            p1_x_q    <= p1_x_d;
            p2_x_q    <= p2_x_d;
            up1_q     <= up1_d;
            up2_q     <= up2_d;
            down1_q   <= down1_d;
            down2_q   <= down2_d;
            score_q   <= score_d;
            pass_q    <= pass_d;
            running_q <= running_d;
        end
    end

    assign pipe1_x      = p1_x_q;
    assign pipe2_x      = p2_x_q;
    assign up_pipe1_y   = up1_q;
    assign up_pipe2_y   = up2_q;
    assign down_pipe1_y = down1_q;
    assign down_pipe2_y = down2_q;
    assign score        = score_q;
    assign pass_pulse   = pass_q;
    assign running      = running_q;

endmodule

// File: tb/tb_pipe_scheduler.sv
// Bench for pipe_scheduler: game-rule model checked every cycle plus directed literal checks;
// a second instance with a fast scroll speed exercises score saturation.
module tb_pipe_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tick = 1'b0, start = 1'b0, go = 1'b0;
    logic tick2 = 1'b0, start2 = 1'b0;

    logic [9:0] pipe1_x, up1, down1, pipe2_x, up2, down2, score;
    logic       running, pass_pulse;
    logic [9:0] s_p1, s_u1, s_d1, s_p2, s_u2, s_d2, s_score;
    logic       s_run, s_pass;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    pipe_scheduler u_dut (
        .clk(clk), .rst(rst), .frame_tick(tick), .start(start), .gameover(go),
        .pipe1_x(pipe1_x), .up_pipe1_y(up1), .down_pipe1_y(down1),
        .pipe2_x(pipe2_x), .up_pipe2_y(up2), .down_pipe2_y(down2),
        .running(running), .pass_pulse(pass_pulse), .score(score)
    );

    pipe_scheduler #(.SPEED(100)) u_sat (
        .clk(clk), .rst(rst), .frame_tick(tick2), .start(start2), .gameover(1'b0),
        .pipe1_x(s_p1), .up_pipe1_y(s_u1), .down_pipe1_y(s_d1),
        .pipe2_x(s_p2), .up_pipe2_y(s_u2), .down_pipe2_y(s_d2),
        .running(s_run), .pass_pulse(s_pass), .score(s_score)
    );

    // Game-rule model: phase, pipe geometry, score, random source
    localparam int SI = 0, SR = 1, SO = 2;
    typedef struct {
        int st; int x1; int x2; int u1; int u2; int d1; int d2;
        int score; int pass; int run; int lfsr;
    } mdl_t;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.st = SI; m.x1 = 409; m.x2 = 614; m.u1 = 150; m.u2 = 150;
        m.d1 = 270; m.d2 = 270; m.score = 0; m.pass = 0; m.run = 0; m.lfsr = 'hA5;
        return m;
    endfunction

    function automatic int lfsr_next(int l);
        int fb;
        fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
        return ((l << 1) & 255) | fb;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, logic t, logic s, logic g, int sp);
        mdl_t n;
        int   up, keep;
        bit   r1, r2, c1, c2;
        n = m;
        n.pass = 0;
        up = 80 + (m.lfsr & 127);
        n.lfsr = lfsr_next(m.lfsr);
        if (m.st == SI) begin
            if (s) n.st = SR;
        end else if (m.st == SR) begin
            if (g) n.st = SO;
            else if (t) begin
                r1 = m.x1 < sp;
                r2 = m.x2 < sp;
                if (r1 && r2) begin
                    n.x1 = 409; n.x2 = 614;
                end else begin
                    n.x2 = r2 ? m.x1 - sp + 205 : m.x2 - sp;
                    n.x1 = r1 ? n.x2 + 205 : m.x1 - sp;
                end
                if (r1) begin n.u1 = up; n.d1 = up + 120; end
                if (r2) begin n.u2 = up; n.d2 = up + 120; end
                c1 = !r1 && m.x1 >= 100 && n.x1 < 100;
                c2 = !r2 && m.x2 >= 100 && n.x2 < 100;
                if (c1 || c2) begin
                    n.pass = 1;
                    if (n.score < 1023) n.score++;
                end
            end
        end else if (s) begin
            keep = n.lfsr;
            n = mdl_reset();
            n.lfsr = keep;
        end
        n.run = (n.st == SR) ? 1 : 0;
        return n;
    endfunction

    mdl_t m1, m2;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m1 = mdl_reset();
            m2 = mdl_reset();
        end else begin
            m1 = mdl_step(m1, tick, start, go, 2);
            m2 = mdl_step(m2, tick2, start2, 1'b0, 100);
        end
    end

    task automatic check_one(input string nm, input mdl_t m,
                             input logic [9:0] a1, input logic [9:0] a2,
                             input logic [9:0] au1, input logic [9:0] au2,
                             input logic [9:0] ad1, input logic [9:0] ad2,
                             input logic [9:0] asc, input logic arun, input logic apass);
        bit ok;
        ok = (a1 == m.x1) && (a2 == m.x2) && (au1 == m.u1) && (au2 == m.u2) &&
             (ad1 == m.d1) && (ad2 == m.d2) && (asc == m.score) &&
             (arun == m.run[0]) && (apass == m.pass[0]) &&
             (au1 >= 80) && (au1 <= 207) && (au2 >= 80) && (au2 <= 207) &&
             (ad1 - au1 == 120) && (ad2 - au2 == 120);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s @%0t got x1=%0d x2=%0d u1=%0d u2=%0d d1=%0d d2=%0d sc=%0d run=%0d pp=%0d required x1=%0d x2=%0d u1=%0d u2=%0d d1=%0d d2=%0d sc=%0d run=%0d pp=%0d",
                      nm, $time, a1, a2, au1, au2, ad1, ad2, asc, arun, apass,
                      m.x1, m.x2, m.u1, m.u2, m.d1, m.d2, m.score, m.run, m.pass);
    endtask

    always @(negedge clk) begin
        check_one("main", m1, pipe1_x, pipe2_x, up1, up2, down1, down2, score, running, pass_pulse);
        check_one("sat", m2, s_p1, s_p2, s_u1, s_u2, s_d1, s_d2, s_score, s_run, s_pass);
    end

    task automatic expect_eq(input string nm, input int got, input int exp);
        checks++;
        if (got == exp) passes++;
        else $display("FAIL %s: got %0d, required %0d", nm, got, exp);
    endtask

    task automatic do_tick();
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    initial begin
        int n, prev_sc;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        expect_eq("reset p1x", pipe1_x, 409);
        expect_eq("reset p2x", pipe2_x, 614);
        expect_eq("reset up1", up1, 150);
        expect_eq("reset down2", down2, 270);
        expect_eq("reset running", running, 0);

        do_start();
        expect_eq("run after start", running, 1);
        repeat (50) do_tick();
        expect_eq("p1x after 50", pipe1_x, 309);
        #2 rst = 1'b1;
        #1;
        expect_eq("async rst p1x", pipe1_x, 409);
        expect_eq("async rst p2x", pipe2_x, 614);
        expect_eq("async rst up1", up1, 150);
        expect_eq("async rst down1", down1, 270);
        expect_eq("async rst running", running, 0);
        @(negedge clk) rst = 1'b0;

        do_start();
        repeat (154) do_tick();
        expect_eq("p1x tick154", pipe1_x, 101);
        expect_eq("pp tick154", pass_pulse, 0);
        do_tick();
        expect_eq("p1x tick155", pipe1_x, 99);
        expect_eq("pp tick155", pass_pulse, 1);
        expect_eq("score tick155", score, 1);
        expect_eq("p2x tick155", pipe2_x, 304);
        @(negedge clk);
        expect_eq("pp one cycle", pass_pulse, 0);
        repeat (50) do_tick();
        expect_eq("respawn p1x", pipe1_x, 409);
        expect_eq("respawn p2x", pipe2_x, 204);
        expect_eq("respawn up range", (up1 >= 80 && up1 <= 207) ? 1 : 0, 1);
        expect_eq("respawn gap", down1 - up1, 120);
        expect_eq("respawn no pp", pass_pulse, 0);

        @(negedge clk) begin tick = 1'b1; go = 1'b1; end
        @(negedge clk) begin tick = 1'b0; go = 1'b0; end
        expect_eq("over p1x", pipe1_x, 409);
        expect_eq("over running", running, 0);
        repeat (5) do_tick();
        expect_eq("frozen p2x", pipe2_x, 204);
        expect_eq("frozen score", score, 1);
        do_start();
        expect_eq("restart p2x", pipe2_x, 614);
        expect_eq("restart up1", up1, 150);
        expect_eq("restart score", score, 0);
        expect_eq("restart running", running, 0);

        for (int k = 0; k < 50; k++) begin
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                tick = 1'($urandom);
                go   = 1'($urandom);
            end
            @(negedge clk) begin tick = 1'b0; go = 1'b0; start = 1'b1; end
            @(negedge clk) start = 1'b0;
            n = $urandom_range(20, 400);
            for (int i = 0; i < n; i++) begin
                @(negedge clk);
                tick  = ($urandom_range(0, 3) != 0);
                start = ($urandom_range(0, 15) == 0);
            end
            @(negedge clk) begin tick = 1'($urandom); start = 1'b0; go = 1'b1; end
            @(negedge clk) begin go = 1'b0; tick = 1'b1; end
            repeat (3) @(negedge clk) tick = 1'($urandom);
            @(negedge clk) begin tick = 1'b0; start = 1'b1; end
            @(negedge clk) start = 1'b0;
        end

        @(negedge clk) start2 = 1'b1;
        @(negedge clk) begin start2 = 1'b0; tick2 = 1'b1; end
        prev_sc = 0;
        n = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (n == 0 && prev_sc == 1023 && m2.pass == 1) begin
                expect_eq("pp at saturation", s_pass, 1);
                n = 1;
            end
            prev_sc = m2.score;
        end
        tick2 = 1'b0;
        expect_eq("saturated score", s_score, 1023);
        expect_eq("saturated pulse seen", n, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
